gc_stream_packer: RTL



---
 rtl/gc_stream_pkg.sv | 36 +++
 rtl/gc_dual_push_fifo.sv | 52 +++++
 rtl/gc_stream_packer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gc_stream_pkg.sv
// Shared types for the garbler output stream packer: record type, tag codes,
// record layout at default widths and the packer FSM state.
package gc_stream_pkg;

   typedef enum logic [1:0] {
      REC_LABEL = 2'd0,
      REC_KEY   = 2'd1,
      REC_TABLE = 2'd2,
      REC_MASK  = 2'd3
   } rec_type_t;

   localparam logic [2:0] TAG_KEY       = 3'b001;
   localparam logic [2:0] TAG_TABLE     = 3'b010;
   localparam logic [2:0] TAG_MASK      = 3'b011;
   localparam int         TAG_LABEL_BIT = 2;

   localparam int GC_S = 8;
   localparam int GC_K = 128;

   // Record layout at the core's default widths; the packer builds the same
   // shape from its own S/K parameters.
   typedef struct packed {
      rec_type_t        rtype;
      logic [GC_S-1:0]  cid;
      logic [GC_S-1:0]  index;
      logic [GC_K-1:0]  data;
   } rec_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/gc_dual_push_fifo.sv
// Circular FIFO with two write lanes and one read port. Lane 0 lands before
// lane 1; the caller only asserts a write lane when a slot is free.
module gc_dual_push_fifo #(
   parameter int  DEPTH = 16,
   parameter type rec_t = logic [7:0]
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr0,
   input  rec_t                     i_rec0,
   input  logic                     i_wr1,
   input  rec_t                     i_rec1,
   input  logic                     i_pop,
   output rec_t                     o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rec_t            r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   w_wptr1;
   logic            w_pop;

   // Lane 1 takes the slot after lane 0 only when lane 0 was written.
   assign w_wptr1 = r_wptr + AW'(i_wr0);
   assign w_pop   = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (i_wr0) r_mem[r_wptr]  <= i_rec0;
      if (i_wr1) r_mem[w_wptr1] <= i_rec1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(i_wr0) + AW'(i_wr1);
         r_rptr  <= r_rptr + AW'(w_pop);
         r_count <= r_count + CW'(i_wr0) + CW'(i_wr1) - CW'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/gc_stream_packer.sv
// Turns the garbler's tagged two-lane output into typed records and streams
// them out one per cycle. Optional macro GC_STREAM_DROP_CNT_EN adds drop_cnt.
module gc_stream_packer
   import gc_stream_pkg::*;
#(
   parameter int S     = 8,
   parameter int K     = 128,
   parameter int CC    = 2,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    tag_t1,
   input  logic [S-1:0]  cid,
   input  logic [S-1:0]  index0_t1,
   input  logic [S-1:0]  index1_t1,
   input  logic [K-1:0]  data0_t1,
   input  logic [K-1:0]  data1_t1,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_type,
   output logic [S-1:0]  out_cid,
   output logic [S-1:0]  out_index,
   output logic [K-1:0]  out_data,
   output logic          done,
   output logic          overflow,
`ifdef GC_STREAM_DROP_CNT_EN
   output logic [15:0]   drop_cnt,
`endif
   output logic [1:0]    dbg_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      rec_type_t     rtype;
      logic [S-1:0]  cid;
      logic [S-1:0]  index;
      logic [K-1:0]  data;
   } rec_w_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_overflow;
   logic            w_decode_en;
   logic            w_start_acc;
   logic            w_end_run;
   logic            w_v0;
   logic            w_v1;
   logic            w_wr0;
   logic            w_wr1;
   logic            w_drop0;
   logic            w_drop1;
   rec_w_t          w_rec0;
   rec_w_t          w_rec1;
   rec_w_t          w_head;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_free;

   assign w_end_run   = (cid == S'(CC));
   assign w_decode_en = (r_state == ST_ACTIVE) && !w_end_run;
   assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (w_end_run) w_state_nxt = ST_FLUSH;
         ST_FLUSH:  if (w_count == '0) w_state_nxt = ST_DONE;
         ST_DONE:   if (start) w_state_nxt = ST_ACTIVE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Tag decode into up to two candidate records.
   always_comb begin
      w_v0         = 1'b0;
      w_v1         = 1'b0;
      w_rec0       = '0;
      w_rec1       = '0;
      w_rec0.cid   = cid;
      w_rec1.cid   = cid;
      w_rec0.index = index0_t1;
      w_rec1.index = index1_t1;
      w_rec0.data  = data0_t1;
      w_rec1.data  = data1_t1;
      if (w_decode_en) begin
         if (tag_t1[TAG_LABEL_BIT]) begin
            w_rec0.rtype = REC_LABEL;
            w_rec1.rtype = REC_LABEL;
            w_v0         = tag_t1[0];
            w_v1         = tag_t1[1];
         end else begin
            case (tag_t1)
               TAG_KEY: begin
                  w_rec0.rtype = REC_KEY;
                  w_rec1.rtype = REC_KEY;
                  w_rec0.index = '0;
                  w_rec1.index = S'(1);
                  w_v0         = 1'b1;
                  w_v1         = 1'b1;
               end
               TAG_TABLE: begin
                  w_rec0.rtype = REC_TABLE;
                  w_rec1.rtype = REC_TABLE;
                  w_v0         = 1'b1;
                  w_v1         = 1'b1;
               end
               TAG_MASK: begin
                  w_rec0.rtype = REC_MASK;
                  w_rec0.index = '0;
                  w_v0         = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Space is judged on the registered count: a same-cycle pop frees nothing.
   assign w_free  = CW'(DEPTH) - w_count;
   assign w_wr0   = w_v0 && (w_free >= CW'(1));
   assign w_wr1   = w_v1 && (w_free >= (w_wr0 ? CW'(2) : CW'(1)));
   assign w_drop0 = w_v0 && !w_wr0;
   assign w_drop1 = w_v1 && !w_wr1;

   always_ff @(posedge clk) begin
      if (rst)                    r_overflow <= 1'b0;
      else if (w_start_acc)       r_overflow <= 1'b0;
      else if (w_drop0 | w_drop1) r_overflow <= 1'b1;
   end

`ifdef GC_STREAM_DROP_CNT_EN
   logic [15:0] r_drop_cnt;
   logic [16:0] w_drop_sum;

   assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop0) + 17'(w_drop1);

   always_ff @(posedge clk) begin
      if (rst)              r_drop_cnt <= '0;
      else if (w_start_acc) r_drop_cnt <= '0;
      else                  r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   assign drop_cnt = r_drop_cnt;
`endif

   gc_dual_push_fifo #(
      .DEPTH (DEPTH),
      .rec_t (rec_w_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr0   (w_wr0),
      .i_rec0  (w_rec0),
      .i_wr1   (w_wr1),
      .i_rec1  (w_rec1),
      .i_pop   (out_ready),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // valid/ready: a record transfers on any edge where out_valid && out_ready;
   // while out_valid is high and out_ready low the head fields do not change.
   assign out_valid = (w_count != '0);
   assign out_type  = out_valid ? w_head.rtype : 2'd0;
   assign out_cid   = out_valid ? w_head.cid   : '0;
   assign out_index = out_valid ? w_head.index : '0;
   assign out_data  = out_valid ? w_head.data  : '0;
   assign done      = (r_state == ST_DONE);
   assign overflow  = r_overflow;
   assign dbg_state = r_state;

endmodule
